// File: rtl/bf16_operand_streamer.sv
// rtl/bf16_operand_streamer.sv - operand-pair memory streamed into the bf16 multiplier over stb/ack
module bf16_operand_streamer #(
  parameter int DW    = 16,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic [AW-1:0]   load_addr,
  input  logic [2*DW-1:0] load_data,
  input  logic [AW:0]     num_ops,
  input  logic            start,
  output logic [2*DW-1:0] output_mul,
  output logic            output_mul_stb,
  input  logic            output_mul_ack,
  output logic            busy,
  output logic            done,
  output logic [AW:0]     count
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     num_q, num_d;
  logic [AW:0]     count_q, count_d;
  logic [2*DW-1:0] data_q, data_d;
  logic            stb_q, stb_d;
  logic            busy_q, done_q;

  logic [2*DW-1:0] mem [DEPTH];
  logic [AW-1:0]   rd_ptr_nxt;
  logic            wr_hit0;

  assign rd_ptr_nxt = rd_ptr_q + AW'(1);
  // A write to address 0 landing with start must be the first word sent.
  assign wr_hit0    = load_en && (load_addr == '0);

  always_ff @(posedge clk) begin
    if (load_en && state_q == IDLE) mem[load_addr] <= load_data;
  end

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    num_d    = num_q;
    count_d  = count_q;
    data_d   = data_q;
    stb_d    = stb_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          count_d = '0;
          if (num_ops != '0) begin
            num_d    = num_ops;
            rd_ptr_d = '0;
            data_d   = wr_hit0 ? load_data : mem[0];
            stb_d    = 1'b1;
            state_d  = SEND;
          end else begin
            state_d  = DONE;
          end
        end
      end
      SEND: begin
        if (stb_q && output_mul_ack) begin
          count_d = count_q + (AW+1)'(1);
          if (count_q == num_q - (AW+1)'(1)) begin
            stb_d   = 1'b0;
            state_d = DONE;
          end else begin
            rd_ptr_d = rd_ptr_nxt;
            data_d   = mem[rd_ptr_nxt];
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      num_q    <= '0;
      count_q  <= '0;
      data_q   <= '0;
      stb_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      num_q    <= num_d;
      count_q  <= count_d;
      data_q   <= data_d;
      stb_q    <= stb_d;
      busy_q   <= (state_d == SEND);
      done_q   <= (state_d == DONE);
    end
  end

  assign output_mul     = data_q;
  assign output_mul_stb = stb_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign count          = count_q;

endmodule

// File: tb/tb_bf16_operand_streamer.sv
// tb/tb_bf16_operand_streamer.sv - directed vectors and scoreboarded streams for bf16_operand_streamer
module tb_bf16_operand_streamer;
  localparam int DW = 16;
  localparam int DEPTH = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            load_en;
  logic [AW-1:0]   load_addr;
  logic [2*DW-1:0] load_data;
  logic [AW:0]     num_ops;
  logic            start;
  logic [2*DW-1:0] output_mul;
  logic            output_mul_stb;
  logic            output_mul_ack;
  logic            busy;
  logic            done;
  logic [AW:0]     count;

  bf16_operand_streamer #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .num_ops(num_ops), .start(start), .output_mul(output_mul), .output_mul_stb(output_mul_stb),
    .output_mul_ack(output_mul_ack), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic        stb;
    logic [31:0] word;
    logic        dn;
    logic        bsy;
    logic [5:0]  cnt;
  } vec_t;

  logic [31:0] model [DEPTH];
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a[AW-1:0]; load_data = d;
    step();
    load_en = 1'b0;
    model[a] = d;
  endtask

  task automatic do_start(input int k);
    num_ops = k[AW:0]; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Scoreboard a whole stream: every transfer is matched against the model memory.
  task automatic run_stream(input int k, input bit rnd);
    int idx = 0;
    int cyc = 0;
    bit fin = 1'b0;
    bit last = 1'b0;
    bit hold = 1'b0;
    logic [31:0] prev = '0;
    chk("stb_after_start", output_mul_stb, 1'b1);
    chk("busy_after_start", busy, 1'b1);
    while (!fin && cyc < 2000) begin
      output_mul_ack = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (last) begin
        fin = 1'b1;
        chk("done_after_last", done, 1'b1);
        chk("stb_low_at_done", output_mul_stb, 1'b0);
        chk("busy_low_at_done", busy, 1'b0);
        chk("count_final", count, k);
        if (!rnd) chk("full_rate_cycles", cyc, k);
      end else begin
        if (done) chk("early_done", done, 1'b0);
        if (output_mul_stb) begin
          if (hold) chk("hold_stable", output_mul, prev);
          if (output_mul_ack) begin
            chk($sformatf("word%0d", idx), output_mul, model[idx % DEPTH]);
            idx++;
            hold = 1'b0;
            if (idx == k) last = 1'b1;
          end else begin
            hold = 1'b1;
            prev = output_mul;
          end
        end
      end
      if (!fin) begin
        step();
        cyc++;
      end
    end
    if (!fin) chk("stream_timeout", 1'b0, 1'b1);
    output_mul_ack = 1'b0;
    step();
    chk("done_one_cycle", done, 1'b0);
  endtask

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 32'h3F804000, 1'b0, 1'b1, 6'd0};
    tbl[1]  = '{1'b0, 1'b1, 32'h3F814000, 1'b0, 1'b1, 6'd1};
    tbl[2]  = '{1'b0, 1'b1, 32'h3F814000, 1'b0, 1'b1, 6'd1};
    tbl[3]  = '{1'b0, 1'b1, 32'h3F814000, 1'b0, 1'b1, 6'd1};
    tbl[4]  = '{1'b1, 1'b1, 32'h3F814000, 1'b0, 1'b1, 6'd1};
    tbl[5]  = '{1'b0, 1'b1, 32'h3F824000, 1'b0, 1'b1, 6'd2};
    tbl[6]  = '{1'b1, 1'b1, 32'h3F824000, 1'b0, 1'b1, 6'd2};
    tbl[7]  = '{1'b0, 1'b1, 32'h3F834000, 1'b0, 1'b1, 6'd3};
    tbl[8]  = '{1'b1, 1'b1, 32'h3F834000, 1'b0, 1'b1, 6'd3};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 6'd4};
    tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 6'd4};

    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    num_ops = '0; start = 1'b0; output_mul_ack = 1'b0;
    step(); step();
    chk("rst_stb", output_mul_stb, 1'b0);
    chk("rst_data", output_mul, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_count", count, 6'd0);
    rst = 1'b0;
    step();

    // Single pair
    load(0, 32'h3F804000);
    do_start(1);
    chk("single_word", output_mul, 32'h3F804000);
    run_stream(1, 1'b0);

    // Full rate over every address
    for (int i = 0; i < DEPTH; i++) load(i, {16'h3F80 + 16'(i), 16'h4000});
    do_start(32);
    run_stream(32, 1'b0);

    // Backpressure, cycle by cycle
    do_start(4);
    for (int i = 0; i < 11; i++) begin
      output_mul_ack = tbl[i].ack;
      chk($sformatf("bp%0d_stb", i), output_mul_stb, tbl[i].stb);
      if (tbl[i].stb) chk($sformatf("bp%0d_word", i), output_mul, tbl[i].word);
      chk($sformatf("bp%0d_done", i), done, tbl[i].dn);
      chk($sformatf("bp%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("bp%0d_count", i), count, tbl[i].cnt);
      step();
    end
    output_mul_ack = 1'b0;

    // Random backpressure, then wrap past DEPTH
    do_start(6);
    run_stream(6, 1'b1);
    do_start(34);
    run_stream(34, 1'b0);

    // Zero length
    do_start(0);
    chk("zero_stb", output_mul_stb, 1'b0);
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    chk("zero_count", count, 6'd0);
    step();
    chk("zero_done_clear", done, 1'b0);
    chk("zero_stb_idle", output_mul_stb, 1'b0);

    // Mid-stream start/load ignored, then asynchronous reset
    do_start(10);
    output_mul_ack = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        start = 1'b1; num_ops = 6'd3;
        load_en = 1'b1; load_addr = 5'd3; load_data = 32'hDEADBEEF;
      end
      chk($sformatf("mid_word%0d", c), output_mul, model[c]);
      step();
      start = 1'b0; load_en = 1'b0;
    end
    output_mul_ack = 1'b0;
    chk("mid_count5", count, 6'd5);
    chk("mid_stb", output_mul_stb, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_stb", output_mul_stb, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_count", count, 6'd0);
    chk("async_rst_data", output_mul, 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_idle_stb", output_mul_stb, 1'b0);
    do_start(4);
    run_stream(4, 1'b0);

    // Load to address 0 coinciding with start is sent first
    load_en = 1'b1; load_addr = '0; load_data = 32'h40404040;
    num_ops = 6'd1; start = 1'b1;
    step();
    load_en = 1'b0; start = 1'b0;
    model[0] = 32'h40404040;
    run_stream(1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
